bus_initiator: RTL and testbench



---
 rtl/bus_initiator.sv | 156 +++++++++++++++
 tb/tb_bus_initiator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// bus_initiator: single-word 386-style local-bus initiator.
// Turns one request into a T1/T2 bus cycle, waits for the decoder's READYb,
// and returns read data or a timeout error with a one-cycle ack pulse.
module bus_initiator #(
  parameter int TIMEOUT  = 64,  // max T2 samples of READYb=1 before abort (2..256)
  parameter int IDLE_GAP = 1    // idle cycles after completion before next T1 (0..3)
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_mio,
  input  logic [29:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        ADS,
  output logic        WR,
  output logic        MIO,
  output logic [29:0] A,
  output logic [3:0]  BEb,
  output logic [31:0] D_out,
  output logic        D_oe,
  input  logic [31:0] D_in,
  input  logic        READYb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_GAP
  } state_t;

  // Wait counter holds 0..TIMEOUT-1; the TIMEOUT-th READYb=1 sample aborts.
  localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT - 1);
  // The ack cycle is the first gap cycle, so the gap counter starts at IDLE_GAP-1.
  localparam logic [1:0]     GAP_LOAD = (IDLE_GAP > 0) ? 2'(IDLE_GAP - 1) : 2'd0;

  state_t        r_state;
  logic [CW-1:0] r_wait_cnt;
  logic [1:0]    r_gap_cnt;
  logic          r_busy;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic          r_ads;
  logic          r_wr;
  logic          r_mio;
  logic [29:0]   r_a;
  logic [3:0]    r_beb;
  logic [31:0]   r_dout;
  logic          r_doe;

  // Bus cycle sequencer: state, counters and every registered output.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; RESET only takes effect on a rising clock edge.
    if (RESET) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_ads      <= 1'b1;
      r_wr       <= 1'b0;
      r_mio      <= 1'b1;
      r_a        <= '0;
      r_beb      <= 4'b1111;
      r_dout     <= '0;
      r_doe      <= 1'b0;
    end else begin
      // NOTE: all state uses <= so every register sees pre-edge values of the others.
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state <= S_T1;
            r_busy  <= 1'b1;
            r_ads   <= 1'b0;
            r_wr    <= req_wr;
            r_mio   <= req_mio;
            r_a     <= req_addr;
            r_beb   <= ~req_be;
            r_dout  <= req_wr ? req_wdata : 32'd0;
            r_doe   <= req_wr;
          end
        end

        S_T1: begin
          // READYb is ignored during T1; address phase lasts exactly one cycle.
          r_ads      <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_T2;
        end

        S_T2: begin
          // READYb=0 wins even on the edge where the timeout would expire.
          if (!READYb || (r_wait_cnt == TO_LAST)) begin
            r_ack <= 1'b1;
            r_err <= READYb;
            if (!READYb && !r_wr) begin
              r_rdata <= D_in;
            end
            r_wr       <= 1'b0;
            r_mio      <= 1'b1;
            r_a        <= '0;
            r_beb      <= 4'b1111;
            r_dout     <= '0;
            r_doe      <= 1'b0;
            r_wait_cnt <= '0;
            if (IDLE_GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end

        S_GAP: begin
          if (r_gap_cnt == 2'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 2'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign ADS   = r_ads;
  assign WR    = r_wr;
  assign MIO   = r_mio;
  assign A     = r_a;
  assign BEb   = r_beb;
  assign D_out = r_dout;
  assign D_oe  = r_doe;

endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed bench for bus_initiator (TIMEOUT=8, IDLE_GAP=1).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bus_initiator;

  logic        clk;
  logic        RESET;
  logic        req;
  logic        req_wr;
  logic        req_mio;
  logic [29:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        busy;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        ADS;
  logic        WR;
  logic        MIO;
  logic [29:0] A;
  logic [3:0]  BEb;
  logic [31:0] D_out;
  logic        D_oe;
  logic [31:0] D_in;
  logic        READYb;

  int n_checks = 0;
  int n_errors = 0;

  bus_initiator #(
    .TIMEOUT (8),
    .IDLE_GAP(1)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .req      (req),
    .req_wr   (req_wr),
    .req_mio  (req_mio),
    .req_addr (req_addr),
    .req_be   (req_be),
    .req_wdata(req_wdata),
    .busy     (busy),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .ADS      (ADS),
    .WR       (WR),
    .MIO      (MIO),
    .A        (A),
    .BEb      (BEb),
    .D_out    (D_out),
    .D_oe     (D_oe),
    .D_in     (D_in),
    .READYb   (READYb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    req       = 1'b0;
    req_wr    = 1'b0;
    req_mio   = 1'b1;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    D_in      = '0;
    READYb    = 1'b1;

    // Reset held for two edges.
    cyc();
    cyc();
    RESET = 1'b0;
    check("rst_ads",  32'(ADS),  32'd1);
    check("rst_mio",  32'(MIO),  32'd1);
    check("rst_wr",   32'(WR),   32'd0);
    check("rst_beb",  32'(BEb),  32'hF);
    check("rst_doe",  32'(D_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack",  32'(ack),  32'd0);
    check("rst_a",    32'(A),    32'd0);

    // Memory read, READYb low on third T2 sample.
    req = 1'b1; req_wr = 1'b0; req_mio = 1'b1;
    req_addr = 30'h2000_0004; req_be = 4'hF;
    cyc();                                   // T1
    req = 1'b0;
    check("rd_t1_ads",  32'(ADS),  32'd0);
    check("rd_t1_a",    32'(A),    32'h2000_0004);
    check("rd_t1_beb",  32'(BEb),  32'h0);
    check("rd_t1_mio",  32'(MIO),  32'd1);
    check("rd_t1_wr",   32'(WR),   32'd0);
    check("rd_t1_doe",  32'(D_oe), 32'd0);
    check("rd_t1_busy", 32'(busy), 32'd1);
    cyc();                                   // first T2 cycle
    check("rd_t2_ads", 32'(ADS), 32'd1);
    check("rd_t2_a",   32'(A),   32'h2000_0004);
    check("rd_t2_mio", 32'(MIO), 32'd1);
    cyc();                                   // second T2 cycle
    check("rd_w1_ack", 32'(ack), 32'd0);
    cyc();                                   // third T2 cycle
    check("rd_w2_ack", 32'(ack), 32'd0);
    check("rd_w2_a",   32'(A),   32'h2000_0004);
    READYb = 1'b0; D_in = 32'hDEAD_BEEF;
    cyc();                                   // ack cycle, req+5
    READYb = 1'b1; D_in = '0;
    check("rd_ack",   32'(ack),  32'd1);
    check("rd_err",   32'(err),  32'd0);
    check("rd_rdata", rdata,     32'hDEAD_BEEF);
    check("rd_idle_a",   32'(A),   32'd0);
    check("rd_idle_beb", 32'(BEb), 32'hF);
    check("rd_gap_busy", 32'(busy), 32'd1);
    cyc();
    check("rd_ack_pulse", 32'(ack),  32'd0);
    check("rd_idle_busy", 32'(busy), 32'd0);

    // I/O write, zero-wait; READYb low during T1 must be ignored.
    req = 1'b1; req_wr = 1'b1; req_mio = 1'b0;
    req_addr = 30'h0000_0101; req_be = 4'h3; req_wdata = 32'h1234_5678;
    cyc();                                   // T1
    req = 1'b0;
    READYb = 1'b0;
    check("wr_t1_beb",  32'(BEb),  32'hC);
    check("wr_t1_doe",  32'(D_oe), 32'd1);
    check("wr_t1_dout", D_out,     32'h1234_5678);
    check("wr_t1_mio",  32'(MIO),  32'd0);
    check("wr_t1_wr",   32'(WR),   32'd1);
    cyc();                                   // T2
    check("wr_t2_ack", 32'(ack),  32'd0);
    check("wr_t2_doe", 32'(D_oe), 32'd1);
    check("wr_t2_a",   32'(A),    32'h0000_0101);
    cyc();                                   // ack cycle, req+3
    READYb = 1'b1;
    check("wr_ack",   32'(ack),  32'd1);
    check("wr_err",   32'(err),  32'd0);
    check("wr_rdata", rdata,     32'hDEAD_BEEF);
    check("wr_doe",   32'(D_oe), 32'd0);
    check("wr_wr",    32'(WR),   32'd0);
    cyc();
    check("wr_busy", 32'(busy), 32'd0);

    // Timeout: READYb held high for 8 T2 samples.
    req = 1'b1; req_wr = 1'b0; req_mio = 1'b1;
    req_addr = 30'h0ABC_DEF0; req_be = 4'h1;
    cyc();                                   // T1
    req = 1'b0;
    check("to_t1_beb", 32'(BEb), 32'hE);
    cyc();                                   // first T2 cycle
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("to_wait%0d_ack", i), 32'(ack), 32'd0);
    end
    cyc();                                   // eighth sample expired
    check("to_ack",   32'(ack),  32'd1);
    check("to_err",   32'(err),  32'd1);
    check("to_rdata", rdata,     32'hDEAD_BEEF);
    check("to_ads",   32'(ADS),  32'd1);
    check("to_beb",   32'(BEb),  32'hF);
    check("to_a",     32'(A),    32'd0);
    cyc();
    check("to_busy", 32'(busy), 32'd0);
    check("to_err_pulse", 32'(err), 32'd0);

    // Normal read after timeout.
    req = 1'b1; req_addr = 30'h0000_0010; req_be = 4'hF;
    cyc();                                   // T1
    req = 1'b0;
    cyc();                                   // T2
    READYb = 1'b0; D_in = 32'hCAFE_F00D;
    cyc();
    READYb = 1'b1;
    check("post_to_ack",   32'(ack), 32'd1);
    check("post_to_err",   32'(err), 32'd0);
    check("post_to_rdata", rdata,    32'hCAFE_F00D);
    cyc();

    // READYb low on the very edge the timeout would expire: success.
    req = 1'b1; req_addr = 30'h0000_0020;
    cyc();                                   // T1
    req = 1'b0;
    cyc();                                   // first T2 cycle
    for (int i = 0; i < 7; i++) begin
      cyc();
    end
    check("edge_pre_ack", 32'(ack), 32'd0);
    READYb = 1'b0; D_in = 32'h55AA_55AA;
    cyc();
    READYb = 1'b1;
    check("edge_ack",   32'(ack), 32'd1);
    check("edge_err",   32'(err), 32'd0);
    check("edge_rdata", rdata,    32'h55AA_55AA);
    cyc();

    // Back-to-back with req held high and zero-wait reads.
    req = 1'b1; req_addr = 30'h0000_0030; READYb = 1'b0; D_in = 32'h1111_1111;
    cyc();                                   // first T1
    check("b2b_t1_ads", 32'(ADS), 32'd0);
    cyc();                                   // T2
    check("b2b_t2_ads", 32'(ADS), 32'd1);
    cyc();                                   // first ack
    check("b2b_ack1",     32'(ack), 32'd1);
    check("b2b_ack1_ads", 32'(ADS), 32'd1);
    check("b2b_rdata1",   rdata,    32'h1111_1111);
    cyc();                                   // idle cycle, req accepted here
    check("b2b_idle_ads",  32'(ADS),  32'd1);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    cyc();                                   // second T1, 2 cycles after ack
    req = 1'b0; D_in = 32'h2222_2222;
    check("b2b_t1b_ads", 32'(ADS), 32'd0);
    cyc();                                   // T2
    cyc();                                   // second ack
    check("b2b_ack2",   32'(ack), 32'd1);
    check("b2b_rdata2", rdata,    32'h2222_2222);
    cyc();
    cyc();
    check("b2b_no_extra_ads",  32'(ADS),  32'd1);
    check("b2b_no_extra_busy", 32'(busy), 32'd0);

    // Reset asserted mid-T2 of a write.
    READYb = 1'b1;
    req = 1'b1; req_wr = 1'b1; req_addr = 30'h0000_0040; req_wdata = 32'hA5A5_A5A5;
    cyc();                                   // T1
    req = 1'b0;
    cyc();                                   // T2
    check("mid_t2_doe",  32'(D_oe), 32'd1);
    check("mid_t2_busy", 32'(busy), 32'd1);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    READYb = 1'b0;
    check("mid_rst_ads",   32'(ADS),  32'd1);
    check("mid_rst_doe",   32'(D_oe), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_ack",   32'(ack),  32'd0);
    check("mid_rst_rdata", rdata,     32'd0);
    cyc();
    check("mid_rst_ready_ack1", 32'(ack),  32'd0);
    check("mid_rst_ready_busy", 32'(busy), 32'd0);
    cyc();
    check("mid_rst_ready_ack2", 32'(ack), 32'd0);
    check("mid_rst_ready_ads",  32'(ADS), 32'd1);
    READYb = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
